// File: rtl/divider_arbiter.sv
// -----------------------------------------------------------------------------
// divider_arbiter
// Shares one iterative binary divider among NUM_REQ requesters. Requests are
// granted round-robin, operands are captured at grant, obviously bad
// operations (divide-by-zero, quotient wider than 8 bits) are answered
// without engaging the divider, and a watchdog aborts a divider that never
// reports done. Every answer carries the requester index and a 2-bit status.
//
// Ports
//   clk, reset        clock (posedge) and synchronous active-high reset
//   req_valid_i       per-requester request level, held until granted
//   req_dividend_i    packed 16-bit dividends, requester i at [16*i +: 16]
//   req_divisor_i     packed 16-bit divisors, same packing
//   req_ready_o       one-hot, one-cycle grant
//   resp_valid_o      response valid, held until resp_ready_i
//   resp_ready_i      response consumer ready
//   resp_id_o         index of the requester being answered
//   resp_quotient_o   8-bit quotient, 8'hFF on any error
//   resp_status_o     00 ok, 01 divide-by-zero, 10 overflow, 11 timeout
//   div_enable_o      one-cycle start pulse to the divider
//   div_dividend_o    captured dividend, stable from grant to next grant
//   div_divisor_o     captured divisor, stable from grant to next grant
//   div_quotient_i    divider quotient
//   div_done_i        divider done pulse
// -----------------------------------------------------------------------------
module divider_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 32,
    localparam int IDW = $clog2(NUM_REQ),
    localparam int CW  = $clog2(TIMEOUT + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [16*NUM_REQ-1:0]   req_dividend_i,
    input  logic [16*NUM_REQ-1:0]   req_divisor_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [IDW-1:0]          resp_id_o,
    output logic [7:0]              resp_quotient_o,
    output logic [1:0]              resp_status_o,
    output logic                    div_enable_o,
    output logic [15:0]             div_dividend_o,
    output logic [15:0]             div_divisor_o,
    input  logic [7:0]              div_quotient_i,
    input  logic                    div_done_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_DBZ = 2'b01;
    localparam logic [1:0] ST_OVF = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    state_t               state_q,         state_d;
    logic [IDW-1:0]       rr_ptr_q,        rr_ptr_d;
    logic [NUM_REQ-1:0]   req_ready_q,     req_ready_d;
    logic                 resp_valid_q,    resp_valid_d;
    logic [IDW-1:0]       resp_id_q,       resp_id_d;
    logic [7:0]           resp_quotient_q, resp_quotient_d;
    logic [1:0]           resp_status_q,   resp_status_d;
    logic                 div_enable_q,    div_enable_d;
    logic [15:0]          div_dividend_q,  div_dividend_d;
    logic [15:0]          div_divisor_q,   div_divisor_d;
    logic [CW-1:0]        wait_cnt_q,      wait_cnt_d;

    logic                 found_s;
    logic                 hit_s;
    logic [IDW-1:0]       grant_s;
    logic [IDW:0]         idx_s;
    logic [IDW-1:0]       next_rr_s;
    logic [15:0]          sel_dividend_s;
    logic [15:0]          sel_divisor_s;
    logic                 div_zero_s;
    logic                 div_ovf_s;

    // Round-robin search: first valid requester at or above rr_ptr, with wrap.
    always_comb begin
        found_s = 1'b0;
        hit_s   = 1'b0;
        grant_s = '0;
        idx_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s   = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            idx_s   = (idx_s >= (IDW+1)'(NUM_REQ)) ? (idx_s - (IDW+1)'(NUM_REQ)) : idx_s;
            hit_s   = req_valid_i[idx_s[IDW-1:0]] && !found_s;
            grant_s = hit_s ? idx_s[IDW-1:0] : grant_s;
            found_s = found_s | hit_s;
        end
    end

    // Operand selection and screening for the candidate grant.
    always_comb begin
        sel_dividend_s = req_dividend_i[{grant_s, 4'b0000} +: 16];
        sel_divisor_s  = req_divisor_i[{grant_s, 4'b0000} +: 16];
        next_rr_s      = (grant_s == IDW'(NUM_REQ - 1)) ? '0 : (grant_s + IDW'(1));
        div_zero_s     = (sel_divisor_s == 16'h0000);
        // Quotient fits in 8 bits only while dividend < divisor * 256.
        div_ovf_s      = ({8'h00, sel_dividend_s} >= {sel_divisor_s, 8'h00});
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        req_ready_d     = '0;
        resp_valid_d    = resp_valid_q;
        resp_id_d       = resp_id_q;
        resp_quotient_d = resp_quotient_q;
        resp_status_d   = resp_status_q;
        div_enable_d    = 1'b0;
        div_dividend_d  = div_dividend_q;
        div_divisor_d   = div_divisor_q;
        wait_cnt_d      = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    req_ready_d            = '0;
                    req_ready_d[grant_s]   = 1'b1;
                    rr_ptr_d               = next_rr_s;
                    resp_id_d              = grant_s;
                    div_dividend_d         = sel_dividend_s;
                    div_divisor_d          = sel_divisor_s;
                    if (div_zero_s) begin
                        state_d         = RESP;
                        resp_valid_d    = 1'b1;
                        resp_quotient_d = 8'hFF;
                        resp_status_d   = ST_DBZ;
                    end else if (div_ovf_s) begin
                        state_d         = RESP;
                        resp_valid_d    = 1'b1;
                        resp_quotient_d = 8'hFF;
                        resp_status_d   = ST_OVF;
                    end else begin
                        // Enable register rises with ISSUE so the pulse covers exactly that cycle.
                        state_d         = ISSUE;
                        div_enable_d    = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d    = WAIT;
                wait_cnt_d = '0;
            end
            WAIT: begin
                if (div_done_i) begin
                    state_d         = RESP;
                    resp_valid_d    = 1'b1;
                    resp_quotient_d = div_quotient_i;
                    resp_status_d   = ST_OK;
                    wait_cnt_d      = '0;
                end else if ((wait_cnt_q + CW'(1)) == CW'(TIMEOUT)) begin
                    state_d         = RESP;
                    resp_valid_d    = 1'b1;
                    resp_quotient_d = 8'hFF;
                    resp_status_d   = ST_TMO;
                    wait_cnt_d      = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end else begin
                    state_d      = RESP;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            rr_ptr_q        <= '0;
            req_ready_q     <= '0;
            resp_valid_q    <= 1'b0;
            resp_id_q       <= '0;
            resp_quotient_q <= 8'h00;
            resp_status_q   <= 2'b00;
            div_enable_q    <= 1'b0;
            div_dividend_q  <= 16'h0000;
            div_divisor_q   <= 16'h0000;
            wait_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_id_q       <= resp_id_d;
            resp_quotient_q <= resp_quotient_d;
            resp_status_q   <= resp_status_d;
            div_enable_q    <= div_enable_d;
            div_dividend_q  <= div_dividend_d;
            div_divisor_q   <= div_divisor_d;
            wait_cnt_q      <= wait_cnt_d;
        end
    end

    assign req_ready_o     = req_ready_q;
    assign resp_valid_o    = resp_valid_q;
    assign resp_id_o       = resp_id_q;
    assign resp_quotient_o = resp_quotient_q;
    assign resp_status_o   = resp_status_q;
    assign div_enable_o    = div_enable_q;
    assign div_dividend_o  = div_dividend_q;
    assign div_divisor_o   = div_divisor_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// -----------------------------------------------------------------------------
// tb_divider_arbiter
// Directed bench for divider_arbiter with a small behavioural divider that
// answers a fixed number of cycles after div_enable (or never, when disabled).
// -----------------------------------------------------------------------------
module tb_divider_arbiter;

    logic          clk;
    logic          reset;
    logic [3:0]    req_valid;
    logic [63:0]   req_dividend;
    logic [63:0]   req_divisor;
    logic [3:0]    req_ready_o;
    logic          resp_valid_o;
    logic          resp_ready;
    logic [1:0]    resp_id_o;
    logic [7:0]    resp_quotient_o;
    logic [1:0]    resp_status_o;
    logic          div_enable_o;
    logic [15:0]   div_dividend_o;
    logic [15:0]   div_divisor_o;
    logic [7:0]    div_quotient;
    logic          div_done;

    int n_assert = 0;
    int n_fail   = 0;
    int en_cnt   = 0;
    logic model_en;
    int   lat;

    divider_arbiter #(.NUM_REQ(4), .TIMEOUT(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid),
        .req_dividend_i  (req_dividend),
        .req_divisor_i   (req_divisor),
        .req_ready_o     (req_ready_o),
        .resp_valid_o    (resp_valid_o),
        .resp_ready_i    (resp_ready),
        .resp_id_o       (resp_id_o),
        .resp_quotient_o (resp_quotient_o),
        .resp_status_o   (resp_status_o),
        .div_enable_o    (div_enable_o),
        .div_dividend_o  (div_dividend_o),
        .div_divisor_o   (div_divisor_o),
        .div_quotient_i  (div_quotient),
        .div_done_i      (div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural divider: done pulse 4 cycles after enable, when enabled.
    always @(posedge clk) begin
        div_done <= 1'b0;
        if (reset) begin
            lat          <= 0;
            div_quotient <= 8'h00;
        end else if (div_enable_o && model_en) begin
            lat <= 4;
        end else if (lat != 0) begin
            lat <= lat - 1;
            if (lat == 1) begin
                div_done     <= 1'b1;
                div_quotient <= (div_divisor_o == 16'h0000) ? 8'hFF : 8'((div_dividend_o / div_divisor_o));
            end
        end
    end

    // Count divider start pulses.
    always @(negedge clk) begin
        if (div_enable_o) en_cnt <= en_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request through to handshake; exp_cyc < 0 skips the latency check.
    task automatic run_one(input string tag, input logic [3:0] mask, input int id,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [7:0] eq, input logic [1:0] es,
                           input int hold, input int exp_en, input int exp_cyc);
        int e0;
        int n;
        e0 = en_cnt;
        n  = 0;
        req_dividend[16*id +: 16] = a;
        req_divisor[16*id +: 16]  = b;
        req_valid = mask;
        @(negedge clk);
        chk({tag, "_grant"}, {28'h0, req_ready_o}, 32'(1) << id);
        req_valid = 4'b0000;
        while (!resp_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'h0, resp_valid_o}, 32'h1);
        if (exp_cyc >= 0) chk({tag, "_cycles"}, n, exp_cyc);
        repeat (hold) @(negedge clk);
        chk({tag, "_valid_held"}, {31'h0, resp_valid_o}, 32'h1);
        chk({tag, "_id"}, {30'h0, resp_id_o}, id);
        chk({tag, "_q"}, {24'h0, resp_quotient_o}, {24'h0, eq});
        chk({tag, "_st"}, {30'h0, resp_status_o}, {30'h0, es});
        chk({tag, "_en"}, en_cnt - e0, exp_en);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, "_drop"}, {31'h0, resp_valid_o}, 32'h0);
    endtask

    initial begin
        int n;
        logic [3:0] gq [$];
        reset        = 1'b1;
        req_valid    = 4'b0000;
        req_dividend = 64'h0;
        req_divisor  = 64'h0;
        resp_ready   = 1'b0;
        model_en     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", {28'h0, req_ready_o}, 32'h0);
        chk("rst_valid", {31'h0, resp_valid_o}, 32'h0);
        chk("rst_en", {31'h0, div_enable_o}, 32'h0);
        chk("rst_dvd", {16'h0, div_dividend_o}, 32'h0);
        chk("rst_q", {24'h0, resp_quotient_o}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Round-robin with all requesters held and consumer always ready.
        for (int i = 0; i < 4; i++) begin
            req_dividend[16*i +: 16] = 16'(10 * (i + 1));
            req_divisor[16*i +: 16]  = 16'd2;
        end
        resp_ready = 1'b1;
        req_valid  = 4'b1111;
        n = 0;
        while (gq.size() < 5 && n < 400) begin
            @(negedge clk);
            n++;
            if (req_ready_o != 4'b0000) gq.push_back(req_ready_o);
        end
        req_valid = 4'b0000;
        repeat (40) @(negedge clk);
        resp_ready = 1'b0;
        chk("rr_count", gq.size(), 32'd5);
        for (int i = 0; i < 5 && i < gq.size(); i++) begin
            chk($sformatf("rr_grant%0d", i), {28'h0, gq[i]}, 32'(1) << (i % 4));
        end

        // 100/7 with the consumer stalled for 10 cycles.
        run_one("t1", 4'b0001, 0, 16'd100, 16'd7, 8'h0E, 2'b00, 10, 1, -1);
        chk("t1_dvd_hold", {16'h0, div_dividend_o}, 32'd100);
        chk("t1_dvs_hold", {16'h0, div_divisor_o}, 32'd7);
        // Divide by zero.
        run_one("dbz", 4'b0100, 2, 16'd55, 16'd0, 8'hFF, 2'b01, 0, 0, 0);
        // Overflow boundaries.
        run_one("ovf_big", 4'b0010, 1, 16'd60000, 16'd3, 8'hFF, 2'b10, 0, 0, 0);
        run_one("q255", 4'b0010, 1, 16'd765, 16'd3, 8'hFF, 2'b00, 0, 1, -1);
        run_one("ovf_768", 4'b0010, 1, 16'd768, 16'd3, 8'hFF, 2'b10, 0, 0, 0);
        // Divider never finishes: watchdog after 32 cycles in WAIT.
        model_en = 1'b0;
        run_one("tmo", 4'b1000, 3, 16'd100, 16'd7, 8'hFF, 2'b11, 0, 1, 33);

        // Reset while waiting on the divider.
        req_dividend[15:0] = 16'd100;
        req_divisor[15:0]  = 16'd7;
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_ready", {28'h0, req_ready_o}, 32'h0);
        chk("mrst_valid", {31'h0, resp_valid_o}, 32'h0);
        chk("mrst_en", {31'h0, div_enable_o}, 32'h0);
        chk("mrst_dvd", {16'h0, div_dividend_o}, 32'h0);
        chk("mrst_dvs", {16'h0, div_divisor_o}, 32'h0);
        chk("mrst_st", {30'h0, resp_status_o}, 32'h0);
        reset    = 1'b0;
        model_en = 1'b1;
        @(negedge clk);
        // Pointer back at 0: requester 0 wins over 3.
        req_dividend[63:48] = 16'd9;
        req_divisor[63:48]  = 16'd3;
        run_one("post", 4'b1001, 0, 16'd200, 16'd10, 8'h14, 2'b00, 0, 1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
